pwm_duty_ramp: RTL and testbench

PWM_DUTY_RAMP -- requirements
Module: pwm_duty_ramp

---
 rtl/pwm_duty_ramp.sv | 95 +++++++++
 tb/tb_pwm_duty_ramp.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_ramp.sv
// Triangle-wave duty generator for an LED PWM stage: dwells at 0, ramps up to
// DUTY_MAX, dwells at the top, then ramps back down, one step per STEP_PERIODS PWM periods.
module pwm_duty_ramp #(
    parameter logic [3:0] DUTY_MAX     = 4'd9,
    parameter logic [7:0] STEP_PERIODS = 8'd10,
    parameter logic [7:0] HOLD_STEPS   = 8'd4
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       en,
    input  logic       period_tc,
    output logic [3:0] duty,
    output logic       duty_upd,
    output logic [1:0] phase
);

    typedef enum logic [1:0] {
        BOTTOM = 2'b00,
        UP     = 2'b01,
        TOP    = 2'b10,
        DOWN   = 2'b11
    } phase_e;

    phase_e     phase_q;
    logic [7:0] step_cnt_q;
    logic [7:0] hold_cnt_q;
    logic [3:0] duty_q;
    logic       duty_upd_q;

    logic       tick;
    logic       step;

    assign tick = en && period_tc;
    assign step = tick && (step_cnt_q == STEP_PERIODS - 8'd1);

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            phase_q    <= BOTTOM;
            step_cnt_q <= 8'd0;
            hold_cnt_q <= 8'd0;
            duty_q     <= 4'd0;
            duty_upd_q <= 1'b0;
        end else begin
            duty_upd_q <= 1'b0;

            if (tick) begin
                step_cnt_q <= step ? 8'd0 : step_cnt_q + 8'd1;
            end

            if (step) begin
                case (phase_q)
                    BOTTOM, TOP: begin
                        // Dwell steps never touch duty; only the phase moves on.
                        if (hold_cnt_q == HOLD_STEPS - 8'd1) begin
                            hold_cnt_q <= 8'd0;
                            phase_q    <= (phase_q == BOTTOM) ? UP : DOWN;
                        end else begin
                            hold_cnt_q <= hold_cnt_q + 8'd1;
                        end
                    end
                    UP: begin
                        if (duty_q < DUTY_MAX) begin
                            duty_q     <= duty_q + 4'd1;
                            duty_upd_q <= 1'b1;
                            if (duty_q + 4'd1 == DUTY_MAX) begin
                                phase_q <= TOP;
                            end
                        end else begin
                            phase_q <= TOP;
                        end
                    end
                    DOWN: begin
                        if (duty_q > 4'd0) begin
                            duty_q     <= duty_q - 4'd1;
                            duty_upd_q <= 1'b1;
                            if (duty_q == 4'd1) begin
                                phase_q <= BOTTOM;
                            end
                        end else begin
                            phase_q <= BOTTOM;
                        end
                    end
                    default: phase_q <= BOTTOM;
                endcase
            end
        end
    end

    assign duty     = duty_q;
    assign duty_upd = duty_upd_q;
    assign phase    = phase_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Bench for pwm_duty_ramp: three parameter sets share one stimulus stream and are
// compared every cycle against a closed-form triangle model of the ramp.
module tb_pwm_duty_ramp;

    logic clk       = 1'b0;
    logic nrst      = 1'b0;
    logic en        = 1'b0;
    logic period_tc = 1'b0;

    logic [3:0] duty_o [3];
    logic       upd_o  [3];
    logic [1:0] ph_o   [3];

    always #5 clk = ~clk;

    pwm_duty_ramp u_dut_a (
        .clk(clk), .nrst(nrst), .en(en), .period_tc(period_tc),
        .duty(duty_o[0]), .duty_upd(upd_o[0]), .phase(ph_o[0])
    );

    pwm_duty_ramp #(.DUTY_MAX(4'd3), .STEP_PERIODS(8'd2), .HOLD_STEPS(8'd1)) u_dut_b (
        .clk(clk), .nrst(nrst), .en(en), .period_tc(period_tc),
        .duty(duty_o[1]), .duty_upd(upd_o[1]), .phase(ph_o[1])
    );

    pwm_duty_ramp #(.DUTY_MAX(4'd5), .STEP_PERIODS(8'd1), .HOLD_STEPS(8'd2)) u_dut_c (
        .clk(clk), .nrst(nrst), .en(en), .period_tc(period_tc),
        .duty(duty_o[2]), .duty_upd(upd_o[2]), .phase(ph_o[2])
    );

    int cfg_dm [3] = '{9, 3, 5};
    int cfg_sp [3] = '{10, 2, 1};
    int cfg_h  [3] = '{4, 1, 2};

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Position in the triangle follows directly from the number of whole steps taken.
    function automatic void ramp_model(input int pulses, input int dm, input int sp,
                                       input int h, output int d, output int ph);
        int k, per, p;
        k   = pulses / sp;
        per = 2 * dm + 2 * h;
        p   = k % per;
        if (p < h) begin
            d = 0; ph = 0;
        end else if (p < h + dm) begin
            d = p - h; ph = 1;
        end else if (p < 2 * h + dm) begin
            d = dm; ph = 2;
        end else begin
            d = dm - (p - 2 * h - dm); ph = 3;
        end
    endfunction

    int pulses     = 0;
    int exp_d  [3] = '{0, 0, 0};
    int exp_ph [3] = '{0, 0, 0};
    int exp_u  [3] = '{0, 0, 0};

    always @(posedge clk or negedge nrst) begin
        int od;
        if (!nrst) begin
            pulses = 0;
            for (int i = 0; i < 3; i++) begin
                exp_d[i] = 0; exp_ph[i] = 0; exp_u[i] = 0;
            end
        end else begin
            if (en && period_tc) pulses++;
            for (int i = 0; i < 3; i++) begin
                od = exp_d[i];
                ramp_model(pulses, cfg_dm[i], cfg_sp[i], cfg_h[i], exp_d[i], exp_ph[i]);
                exp_u[i] = (exp_d[i] != od) ? 1 : 0;
            end
        end
    end

    bit chk_on = 1'b0;

    always @(posedge clk) begin
        #1;
        if (chk_on && nrst) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("duty[%0d]", i), int'(duty_o[i]), exp_d[i]);
                check($sformatf("duty_upd[%0d]", i), int'(upd_o[i]), exp_u[i]);
                check($sformatf("phase[%0d]", i), int'(ph_o[i]), exp_ph[i]);
            end
        end
    end

    task automatic check_all_reset(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_duty[%0d]", tag, i), int'(duty_o[i]), 0);
            check($sformatf("%s_upd[%0d]", tag, i), int'(upd_o[i]), 0);
            check($sformatf("%s_phase[%0d]", tag, i), int'(ph_o[i]), 0);
        end
    endtask

    int b_duty_tab [8] = '{0, 0, 1, 2, 3, 3, 2, 1};
    int b_ph_tab   [8] = '{0, 1, 1, 1, 2, 3, 3, 3};
    int b_upd_tab  [8] = '{1, 0, 1, 1, 1, 0, 1, 1};

    initial begin
        int budget;
        int k;

        repeat (3) @(negedge clk);
        check_all_reset("rst");
        nrst   = 1'b1;
        chk_on = 1'b1;
        en     = 1'b1;

        // Directed ramp: one period_tc pulse every 4 clocks.
        for (int i = 1; i <= 130; i++) begin
            @(negedge clk) period_tc = 1'b1;
            @(negedge clk) period_tc = 1'b0;
            if (i <= 16 && (i % 2) == 0) begin
                k = (i / 2) % 8;
                check("b_duty_seq", int'(duty_o[1]), b_duty_tab[k]);
                check("b_phase_seq", int'(ph_o[1]), b_ph_tab[k]);
                check("b_upd_seq", int'(upd_o[1]), b_upd_tab[k]);
            end
            if (i == 49) check("a_duty_p49", int'(duty_o[0]), 0);
            if (i == 50) begin
                check("a_duty_p50", int'(duty_o[0]), 1);
                check("a_upd_p50", int'(upd_o[0]), 1);
            end
            if (i == 93) begin
                check("a_duty_p93", int'(duty_o[0]), 5);
                en = 1'b0;
                repeat (2) @(negedge clk);
                repeat (100) begin
                    @(negedge clk) period_tc = 1'b1;
                    @(negedge clk) period_tc = 1'b0;
                    repeat (2) @(negedge clk);
                end
                check("a_duty_frozen", int'(duty_o[0]), 5);
                check("a_upd_frozen", int'(upd_o[0]), 0);
                check("a_phase_frozen", int'(ph_o[0]), 1);
                en = 1'b1;
            end
            if (i == 99) check("a_duty_p99", int'(duty_o[0]), 5);
            if (i == 100) begin
                check("a_duty_p100", int'(duty_o[0]), 6);
                check("a_upd_p100", int'(upd_o[0]), 1);
            end
            if (i == 130) begin
                check("a_duty_p130", int'(duty_o[0]), 9);
                check("a_phase_p130", int'(ph_o[0]), 2);
            end
            repeat (2) @(negedge clk);
        end

        // period_tc held high for consecutive cycles counts once per cycle.
        repeat (4) begin
            @(negedge clk) period_tc = 1'b1;
            repeat (2) @(negedge clk);
            @(negedge clk) period_tc = 1'b0;
            repeat (3) @(negedge clk);
        end

        // Randomized run.
        repeat (3000) begin
            @(negedge clk);
            en        = ($urandom_range(0, 9) != 0);
            period_tc = ($urandom_range(0, 2) == 0);
        end

        // Drive A into DOWN at duty 7, then reset between clock edges.
        en = 1'b1;
        budget = 0;
        while (!(exp_d[0] == 7 && exp_ph[0] == 3) && budget < 8000) begin
            @(negedge clk);
            period_tc = ~period_tc;
            budget++;
        end
        check("reach_a_down7_within_budget", (budget < 8000) ? 1 : 0, 1);
        @(negedge clk) period_tc = 1'b0;
        #2 nrst = 1'b0;
        #1 check_all_reset("async_rst");
        repeat (2) @(negedge clk);
        nrst = 1'b1;

        repeat (1500) begin
            @(negedge clk);
            en        = ($urandom_range(0, 7) != 0);
            period_tc = ($urandom_range(0, 1) == 0);
        end

        @(negedge clk);
        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
